// File: rtl/result_writer.sv
// Output stage of the approximate-multiplier datapath: buffers accepted products
// in a small FIFO and writes one batch of NUM results to consecutive RAM addresses.
module result_writer #(
  parameter int unsigned RES_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  res_valid,
  input  logic [RES_WIDTH-1:0]  res_data,
  output logic                  res_ready,
  input  logic                  ram_busy,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [RES_WIDTH-1:0]  ram_wdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  done
);

  localparam int unsigned NUM   = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [OCC_W-1:0]     occ;
  logic [CNT_W-1:0]     accepted;
  logic [CNT_W-1:0]     count_q;
  logic [RES_WIDTH-1:0] mem [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  assign fifo_full  = (occ == OCC_W'(FIFO_DEPTH));
  assign fifo_empty = (occ == '0);

  assign res_ready = (state == RUN) && !fifo_full && (accepted < CNT_W'(NUM));
  assign ram_we    = (state == RUN) && !fifo_empty && !ram_busy;
  assign push      = res_valid && res_ready;
  assign pop       = ram_we;

  // Head is masked while empty so stale buffer contents never reach the RAM bus.
  assign ram_wdata = fifo_empty ? '0 : mem[rd_ptr];
  // The write address is the low bits of the written count; it never wraps mid-batch.
  assign ram_addr  = count_q[ADDR_WIDTH-1:0];
  assign count     = count_q;
  assign done      = (state == DONE);

  // Control state, FIFO pointers and batch counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      accepted <= '0;
      count_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            accepted <= '0;
            count_q  <= '0;
          end
        end
        RUN: begin
          if (push) begin
            wr_ptr   <= wr_ptr + PTR_W'(1);
            accepted <= accepted + CNT_W'(1);
          end
          if (pop) begin
            rd_ptr  <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(NUM - 1)) state <= DONE;
          end
          case ({push, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Buffer storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_data;
  end

endmodule

// File: tb/tb_result_writer.sv
// Directed testbench for result_writer: reset, streaming, back-pressure,
// batch limit, sparse traffic and restart behaviour.
module tb_result_writer;

  localparam int unsigned RW = 32;
  localparam int unsigned AW = 3;
  localparam int unsigned FD = 4;

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          start     = 1'b0;
  logic          res_valid = 1'b0;
  logic [RW-1:0] res_data  = '0;
  logic          ram_busy  = 1'b0;
  logic          res_ready;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [RW-1:0] ram_wdata;
  logic [AW:0]   count;
  logic          done;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int acc_cnt     = 0;

  logic [AW-1:0] wa_q [$];
  logic [RW-1:0] wd_q [$];
  int            wc_q [$];

  result_writer #(.RES_WIDTH(RW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_ready (res_ready),
    .ram_busy  (ram_busy),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .count     (count),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after the rising edge, so the falling edge sees settled values.
  always @(negedge clk) begin
    if (rst) begin
      if (ram_we) begin
        wa_q.push_back(ram_addr);
        wd_q.push_back(ram_wdata);
        wc_q.push_back(cyc);
      end
      if (res_valid && res_ready) acc_cnt = acc_cnt + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset;
    res_valid = 1'b0;
    ram_busy  = 1'b0;
    start     = 1'b0;
    rst       = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic run_batch(input logic [RW-1:0] base, input bit sparse, input bit rand_busy,
                           output bit timeout);
    logic [4:0] pat;
    int ab;
    int n;
    pat = 5'b01101;
    ab  = acc_cnt;
    n   = 0;
    while (!done && n < 300) begin
      res_valid = sparse ? pat[n % 5] : 1'b1;
      res_data  = base + RW'(acc_cnt - ab);
      ram_busy  = rand_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      n++;
    end
    res_valid = 1'b0;
    ram_busy  = 1'b0;
    timeout   = !done;
  endtask

  task automatic test_reset;
    logic [AW+RW+3+AW:0] obs;
    int wb;
    int ab;
    tick();
    obs = {res_ready, ram_we, done, count, ram_addr, ram_wdata};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: outputs=%0h expected 0", obs);
    end
    rst = 1'b1;
    tick();
    ab = acc_cnt;
    ram_busy = 1'b1;
    pulse_start();
    res_valid = 1'b1;
    res_data  = 32'h1;
    tick();
    res_data  = 32'h2;
    tick();
    res_valid = 1'b0;
    vectors++;
    if (acc_cnt - ab != 2 || ram_we !== 1'b0 || res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_prefill: accepted=%0d we=%b ready=%b expected 2/0/1",
               acc_cnt - ab, ram_we, res_ready);
    end
    #2 rst = 1'b0;
    #1;
    obs = {res_ready, ram_we, done, count, ram_addr, ram_wdata};
    vectors++;
    if (obs !== '0) begin
      miscompares++;
      $display("FAIL reset_midrun: outputs=%0h expected 0", obs);
    end
    tick();
    rst      = 1'b1;
    ram_busy = 1'b0;
    tick();
    wb = wa_q.size();
    pulse_start();
    res_valid = 1'b1;
    res_data  = 32'hA5;
    tick();
    res_valid = 1'b0;
    tick();
    tick();
    vectors++;
    if (wa_q.size() != wb + 1) begin
      miscompares++;
      $display("FAIL reset_restart_writes: writes=%0d expected 1", wa_q.size() - wb);
    end else if (wa_q[wb] !== AW'(0) || wd_q[wb] !== 32'hA5) begin
      miscompares++;
      $display("FAIL reset_restart_first: addr=%0d data=%0h expected 0/a5", wa_q[wb], wd_q[wb]);
    end
  endtask

  task automatic test_streaming;
    int wb;
    int c0;
    do_reset();
    wb = wa_q.size();
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      res_valid = 1'b1;
      res_data  = RW'((i + 1) * 32'h11);
      tick();
    end
    res_valid = 1'b0;
    vectors++;
    if (ram_we !== 1'b1 || ram_addr !== AW'(7) || ram_wdata !== 32'h88 ||
        done !== 1'b0 || count !== 4'd7) begin
      miscompares++;
      $display("FAIL stream_last_write: we=%b addr=%0d data=%0h done=%b count=%0d expected 1/7/88/0/7",
               ram_we, ram_addr, ram_wdata, done, count);
    end
    tick();
    vectors++;
    if (done !== 1'b1 || count !== 4'd8 || ram_we !== 1'b0) begin
      miscompares++;
      $display("FAIL stream_done: done=%b count=%0d we=%b expected 1/8/0", done, count, ram_we);
    end
    vectors++;
    if (wa_q.size() != wb + 8) begin
      miscompares++;
      $display("FAIL stream_writes: writes=%0d expected 8", wa_q.size() - wb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (wa_q[wb+i] !== AW'(i) || wd_q[wb+i] !== RW'((i + 1) * 32'h11) || wc_q[wb+i] != c0 + 2 + i) begin
          miscompares++;
          $display("FAIL stream_word%0d: addr=%0d data=%0h cycle=%0d expected %0d/%0h/%0d",
                   i, wa_q[wb+i], wd_q[wb+i], wc_q[wb+i] - c0, i, (i + 1) * 32'h11, 2 + i);
        end
      end
    end
  endtask

  task automatic test_back_pressure;
    int wb;
    int ab;
    int n;
    do_reset();
    wb = wa_q.size();
    ab = acc_cnt;
    ram_busy = 1'b1;
    pulse_start();
    res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      res_data = 32'h101 + RW'(acc_cnt - ab);
      tick();
    end
    vectors++;
    if (acc_cnt - ab != 4 || res_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_fill: accepted=%0d ready=%b expected 4/0", acc_cnt - ab, res_ready);
    end
    for (int i = 0; i < 2; i++) begin
      res_data = 32'h101 + RW'(acc_cnt - ab);
      tick();
    end
    vectors++;
    if (acc_cnt - ab != 4 || res_ready !== 1'b0 || wa_q.size() != wb) begin
      miscompares++;
      $display("FAIL bp_hold: accepted=%0d ready=%b writes=%0d expected 4/0/0",
               acc_cnt - ab, res_ready, wa_q.size() - wb);
    end
    ram_busy = 1'b0;
    n = 0;
    while (acc_cnt - ab < 6 && n < 20) begin
      res_data = 32'h101 + RW'(acc_cnt - ab);
      tick();
      n++;
    end
    res_valid = 1'b0;
    n = 0;
    while (wa_q.size() - wb < 6 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (acc_cnt - ab != 6 || wa_q.size() != wb + 6) begin
      miscompares++;
      $display("FAIL bp_release: accepted=%0d writes=%0d expected 6/6", acc_cnt - ab, wa_q.size() - wb);
    end else begin
      for (int i = 0; i < 6; i++) begin
        vectors++;
        if (wa_q[wb+i] !== AW'(i) || wd_q[wb+i] !== RW'(32'h101 + i)) begin
          miscompares++;
          $display("FAIL bp_word%0d: addr=%0d data=%0h expected %0d/%0h",
                   i, wa_q[wb+i], wd_q[wb+i], i, 32'h101 + i);
        end
      end
    end
  endtask

  task automatic test_batch_limit;
    int wb;
    int ab;
    bit ready_seen;
    do_reset();
    wb = wa_q.size();
    ab = acc_cnt;
    pulse_start();
    res_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      res_data = RW'(32'h200 + i);
      tick();
    end
    vectors++;
    if (acc_cnt - ab != 8 || res_ready !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL limit_accept: accepted=%0d ready=%b done=%b expected 8/0/1",
               acc_cnt - ab, res_ready, done);
    end
    ready_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_data = 32'h2AA;
      tick();
      if (res_ready !== 1'b0) ready_seen = 1'b1;
    end
    vectors++;
    if (ready_seen || acc_cnt - ab != 8) begin
      miscompares++;
      $display("FAIL limit_hold: ready_seen=%b accepted=%0d expected 0/8", ready_seen, acc_cnt - ab);
    end
    vectors++;
    if (wa_q.size() != wb + 8) begin
      miscompares++;
      $display("FAIL limit_writes: writes=%0d expected 8", wa_q.size() - wb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (wa_q[wb+i] !== AW'(i) || wd_q[wb+i] !== RW'(32'h200 + i)) begin
          miscompares++;
          $display("FAIL limit_word%0d: addr=%0d data=%0h expected %0d/%0h",
                   i, wa_q[wb+i], wd_q[wb+i], i, 32'h200 + i);
        end
      end
    end
    pulse_start();
    vectors++;
    if (res_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL limit_rearm: ready=%b expected 1", res_ready);
    end
    res_valid = 1'b0;
  endtask

  task automatic test_sparse;
    int wb;
    bit to;
    do_reset();
    wb = wa_q.size();
    pulse_start();
    run_batch(32'h300, 1'b1, 1'b1, to);
    vectors++;
    if (to) begin
      miscompares++;
      $display("FAIL sparse_timeout: done=%b expected 1", done);
    end
    vectors++;
    if (wa_q.size() != wb + 8) begin
      miscompares++;
      $display("FAIL sparse_writes: writes=%0d expected 8", wa_q.size() - wb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (wa_q[wb+i] !== AW'(i) || wd_q[wb+i] !== RW'(32'h300 + i)) begin
          miscompares++;
          $display("FAIL sparse_word%0d: addr=%0d data=%0h expected %0d/%0h",
                   i, wa_q[wb+i], wd_q[wb+i], i, 32'h300 + i);
        end
      end
    end
  endtask

  task automatic test_restart;
    int wb;
    int ab;
    int n;
    bit to;
    do_reset();
    wb = wa_q.size();
    ab = acc_cnt;
    pulse_start();
    res_valid = 1'b1;
    n = 0;
    while (!done && n < 60) begin
      res_data = 32'h400 + RW'(acc_cnt - ab);
      start    = (acc_cnt - ab == 3);
      tick();
      n++;
    end
    start     = 1'b0;
    res_valid = 1'b0;
    vectors++;
    if (done !== 1'b1 || wa_q.size() != wb + 8) begin
      miscompares++;
      $display("FAIL restart_ignored: done=%b writes=%0d expected 1/8", done, wa_q.size() - wb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (wa_q[wb+i] !== AW'(i) || wd_q[wb+i] !== RW'(32'h400 + i)) begin
          miscompares++;
          $display("FAIL restart_b1_word%0d: addr=%0d data=%0h expected %0d/%0h",
                   i, wa_q[wb+i], wd_q[wb+i], i, 32'h400 + i);
        end
      end
    end
    wb = wa_q.size();
    pulse_start();
    vectors++;
    if (done !== 1'b0 || count !== '0 || ram_addr !== '0) begin
      miscompares++;
      $display("FAIL restart_clear: done=%b count=%0d addr=%0d expected 0/0/0", done, count, ram_addr);
    end
    run_batch(32'h500, 1'b0, 1'b0, to);
    vectors++;
    if (to || wa_q.size() != wb + 8) begin
      miscompares++;
      $display("FAIL restart_b2: timeout=%b writes=%0d expected 0/8", to, wa_q.size() - wb);
    end else begin
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (wa_q[wb+i] !== AW'(i) || wd_q[wb+i] !== RW'(32'h500 + i)) begin
          miscompares++;
          $display("FAIL restart_b2_word%0d: addr=%0d data=%0h expected %0d/%0h",
                   i, wa_q[wb+i], wd_q[wb+i], i, 32'h500 + i);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_batch_limit();
    test_sparse();
    test_restart();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
